// File: rtl/powerup_renderer_if.sv
// Sprite memory read port between the pellet renderer and the pellet ROM.
// The renderer issues the address; the ROM answers one cycle later.
interface powerup_renderer_if;
    logic [7:0] read_address;
    logic [1:0] sprite_data;

    modport master (
        output read_address,
        input  sprite_data
    );

    modport slave (
        input  read_address,
        output sprite_data
    );
endinterface

// File: rtl/powerup_renderer.sv
// Power-pellet renderer: pellet hit test, ROM addressing, blink timer,
// eaten/active bookkeeping and pellets-remaining count.
module powerup_renderer #(
    parameter int SPRITE_DIM   = 15,
    parameter int BLINK_FRAMES = 16,
    parameter int P0_X = 16,  parameter int P0_Y = 48,
    parameter int P1_X = 400, parameter int P1_Y = 48,
    parameter int P2_X = 16,  parameter int P2_Y = 352,
    parameter int P3_X = 400, parameter int P3_Y = 352
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       eat_valid,
    input  logic [1:0] eat_idx,
    input  logic       restore,
    powerup_renderer_if.master mem,
    output logic       pixel_valid,
    output logic [1:0] pixel_color,
    output logic       eaten_pulse,
    output logic [2:0] pellets_left,
    output logic       all_eaten
);

    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [9:0] DIM = 10'(SPRITE_DIM);
    localparam logic [9:0] PX [4] =
        '{10'(P0_X), 10'(P1_X), 10'(P2_X), 10'(P3_X)};
    localparam logic [9:0] PY [4] =
        '{10'(P0_Y), 10'(P1_Y), 10'(P2_Y), 10'(P3_Y)};

    logic [3:0]    active;
    logic          blink_on;
    logic [CW-1:0] blink_cnt;
    logic          hit_q;

    logic [9:0] dx [4];
    logic [9:0] dy [4];
    logic [3:0] hit;
    logic [7:0] sel_dx;
    logic [7:0] sel_dy;

    // Unsigned wrap turns a pixel left/above the sprite into a miss.
    always_comb begin
        hit    = '0;
        sel_dx = '0;
        sel_dy = '0;
        for (int i = 0; i < 4; i++) begin
            dx[i]  = DrawX - PX[i];
            dy[i]  = DrawY - PY[i];
            hit[i] = active[i] && (dx[i] < DIM) && (dy[i] < DIM);
        end
        for (int i = 3; i >= 0; i--) begin
            if (hit[i]) begin
                sel_dx = 8'(dx[i]);
                sel_dy = 8'(dy[i]);
            end
        end
    end

    assign mem.read_address = sel_dy * 8'(SPRITE_DIM) + sel_dx;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            active      <= 4'b1111;
            blink_on    <= 1'b1;
            blink_cnt   <= '0;
            hit_q       <= 1'b0;
            eaten_pulse <= 1'b0;
        end else begin
            hit_q       <= |hit;
            eaten_pulse <= 1'b0;
            if (restore) begin
                active    <= 4'b1111;
                blink_on  <= 1'b1;
                blink_cnt <= '0;
            end else begin
                if (eat_valid && active[eat_idx]) begin
                    active[eat_idx] <= 1'b0;
                    eaten_pulse     <= 1'b1;
                end
                if (frame_start) begin
                    if (blink_cnt == CW'(BLINK_FRAMES - 1)) begin
                        blink_cnt <= '0;
                        blink_on  <= ~blink_on;
                    end else begin
                        blink_cnt <= blink_cnt + CW'(1);
                    end
                end
            end
        end
    end

    assign pixel_valid = hit_q && blink_on && (mem.sprite_data != 2'd0);
    assign pixel_color = pixel_valid ? mem.sprite_data : 2'd0;

    always_comb begin
        pellets_left = '0;
        for (int i = 0; i < 4; i++)
            pellets_left = pellets_left + {2'b00, active[i]};
    end

    assign all_eaten = (pellets_left == 3'd0);

endmodule

// File: tb/tb_powerup_renderer.sv
// Directed bench for powerup_renderer with a frame-count based reference
// model compared every cycle plus literal spot checks.
module tb_powerup_renderer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_start;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       eat_valid;
    logic [1:0] eat_idx;
    logic       restore;
    logic       pixel_valid;
    logic [1:0] pixel_color;
    logic       eaten_pulse;
    logic [2:0] pellets_left;
    logic       all_eaten;

    powerup_renderer_if mem ();

    powerup_renderer dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_start  (frame_start),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .eat_valid    (eat_valid),
        .eat_idx      (eat_idx),
        .restore      (restore),
        .mem          (mem.master),
        .pixel_valid  (pixel_valid),
        .pixel_color  (pixel_color),
        .eaten_pulse  (eaten_pulse),
        .pellets_left (pellets_left),
        .all_eaten    (all_eaten)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;

    int PXM [4] = '{16, 400, 16, 400};
    int PYM [4] = '{48, 48, 352, 352};

    // Reference state: blink derived from frames since restore.
    logic [3:0] m_active = 4'b1111;
    int         m_frames = 0;
    bit         m_hitq   = 0;
    bit         m_pulse  = 0;

    function automatic int find_pellet(int x, int y, logic [3:0] act);
        for (int i = 0; i < 4; i++)
            if (act[i] && x >= PXM[i] && x < PXM[i] + 15 &&
                y >= PYM[i] && y < PYM[i] + 15)
                return i;
        return -1;
    endfunction

    function automatic int exp_addr(int x, int y, logic [3:0] act);
        int p;
        p = find_pellet(x, y, act);
        if (p < 0) return 0;
        return (y - PYM[p]) * 15 + (x - PXM[p]);
    endfunction

    function automatic int popc(logic [3:0] a);
        return int'(a[0]) + int'(a[1]) + int'(a[2]) + int'(a[3]);
    endfunction

    task automatic chk(string name, int actual, int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, actual, expected, $time);
        end
    endtask

    always @(posedge Clk) begin
        if (Reset) begin
            m_active = 4'b1111;
            m_frames = 0;
            m_hitq   = 0;
            m_pulse  = 0;
        end else begin
            m_hitq  = find_pellet(int'(DrawX), int'(DrawY), m_active) >= 0;
            m_pulse = 0;
            if (restore) begin
                m_active = 4'b1111;
                m_frames = 0;
            end else begin
                if (eat_valid && m_active[eat_idx]) begin
                    m_active[eat_idx] = 1'b0;
                    m_pulse = 1;
                end
                if (frame_start) m_frames++;
            end
        end
    end

    always @(negedge Clk) begin
        if (mon_en) begin
            bit vis;
            int pv;
            vis = ((m_frames / 16) % 2) == 0;
            pv  = (m_hitq && vis && mem.sprite_data != 0) ? 1 : 0;
            chk("m_addr", int'(mem.read_address),
                exp_addr(int'(DrawX), int'(DrawY), m_active));
            chk("m_valid", int'(pixel_valid), pv);
            chk("m_color", int'(pixel_color), pv ? int'(mem.sprite_data) : 0);
            chk("m_pulse", int'(eaten_pulse), int'(m_pulse));
            chk("m_left", int'(pellets_left), popc(m_active));
            chk("m_all", int'(all_eaten), int'(popc(m_active) == 0));
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge Clk);
    endtask

    task automatic eat(int idx);
        eat_valid = 1'b1;
        eat_idx   = 2'(idx);
        step();
        eat_valid = 1'b0;
    endtask

    task automatic frames(int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
        end
    endtask

    task automatic do_restore();
        restore = 1'b1;
        step();
        restore = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b1; frame_start = 0; DrawX = 0; DrawY = 0;
        eat_valid = 0; eat_idx = 0; restore = 0; mem.sprite_data = 0;
        step(); step();
        mon_en = 1;
        at_neg();
        chk("rst_valid", int'(pixel_valid), 0);
        chk("rst_color", int'(pixel_color), 0);
        chk("rst_left", int'(pellets_left), 4);
        chk("rst_all", int'(all_eaten), 0);
        Reset = 1'b0;
        step();

        DrawX = 16; DrawY = 48;
        at_neg(); chk("p0_tl_addr", int'(mem.read_address), 0);
        step(); mem.sprite_data = 2;
        at_neg();
        chk("p0_tl_valid", int'(pixel_valid), 1);
        chk("p0_tl_color", int'(pixel_color), 2);
        chk("p0_tl_left", int'(pellets_left), 4);

        DrawX = 30; DrawY = 62;
        at_neg(); chk("p0_br_addr", int'(mem.read_address), 224);
        step();
        DrawX = 31;
        at_neg(); chk("x31_addr", int'(mem.read_address), 0);
        step(); mem.sprite_data = 3;
        at_neg(); chk("x31_valid", int'(pixel_valid), 0);
        DrawX = 15;
        at_neg(); chk("x15_addr", int'(mem.read_address), 0);
        step();
        at_neg(); chk("x15_valid", int'(pixel_valid), 0);

        DrawX = 17; DrawY = 49; mem.sprite_data = 1;
        at_neg(); chk("opq_addr", int'(mem.read_address), 16);
        step(); mem.sprite_data = 0;
        at_neg();
        chk("opq_valid", int'(pixel_valid), 0);
        chk("opq_color", int'(pixel_color), 0);

        DrawX = 0; DrawY = 0;
        eat(2);
        at_neg();
        chk("eat2_pulse", int'(eaten_pulse), 1);
        chk("eat2_left", int'(pellets_left), 3);
        step();
        at_neg(); chk("eat2_pulse_end", int'(eaten_pulse), 0);
        DrawX = 20; DrawY = 355;
        at_neg(); chk("p2_addr", int'(mem.read_address), 0);
        step(); mem.sprite_data = 1;
        at_neg(); chk("p2_valid", int'(pixel_valid), 0);
        eat(2);
        at_neg();
        chk("reeat_pulse", int'(eaten_pulse), 0);
        chk("reeat_left", int'(pellets_left), 3);
        eat(0); eat(1); eat(3);
        at_neg();
        chk("all_left", int'(pellets_left), 0);
        chk("all_eaten", int'(all_eaten), 1);

        // Edge sweep around P1 for the per-cycle model.
        do_restore();
        for (int y = 46; y <= 64; y += 3)
            for (int x = 397; x <= 416; x++) begin
                DrawX = 10'(x); DrawY = 10'(y);
                mem.sprite_data = 2'(x % 4);
                step();
            end

        DrawX = 16; DrawY = 48; mem.sprite_data = 1;
        step();
        frames(16);
        at_neg(); chk("blink_off", int'(pixel_valid), 0);
        frames(16);
        at_neg(); chk("blink_on", int'(pixel_valid), 1);
        frames(20);
        at_neg(); chk("f20_hidden", int'(pixel_valid), 0);
        do_restore();
        at_neg(); chk("restore_vis", int'(pixel_valid), 1);
        frames(15);
        at_neg(); chk("f15_vis", int'(pixel_valid), 1);
        frames(1);
        at_neg(); chk("f16_hidden", int'(pixel_valid), 0);
        do_restore();

        eat(2); eat(3);
        at_neg(); chk("a0011_left", int'(pellets_left), 2);
        restore = 1'b1; eat_valid = 1'b1; eat_idx = 2'd1;
        step();
        restore = 1'b0; eat_valid = 1'b0;
        at_neg();
        chk("rst_eat_pulse", int'(eaten_pulse), 0);
        chk("rst_eat_left", int'(pellets_left), 4);

        frame_start = 1'b1; eat_valid = 1'b1; eat_idx = 2'd3;
        step();
        frame_start = 1'b0; eat_valid = 1'b0;
        at_neg();
        chk("fs_eat_pulse", int'(eaten_pulse), 1);
        chk("fs_eat_left", int'(pellets_left), 3);

        DrawX = 20; DrawY = 50; mem.sprite_data = 3;
        step();
        at_neg(); chk("row_valid", int'(pixel_valid), 1);
        Reset = 1'b1;
        step();
        at_neg();
        chk("midrst_valid", int'(pixel_valid), 0);
        chk("midrst_left", int'(pellets_left), 4);
        Reset = 1'b0;
        step(); step();

        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
